// File: rtl/ss_pkg.sv
// Shared types and helpers for the step-down soft-start sequencer.
package ss_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PRE   = 3'd1,
    RAMP  = 3'd2,
    REG   = 3'd3,
    FAULT = 3'd4
  } ss_state_e;

  // Minimum bit width able to hold values 0..value-1 (never below 1 bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((32'd1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ss_timer.sv
// Clearable up-counter with a terminal-count flag against a runtime limit.
module ss_timer
  import ss_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == last);

endmodule

// File: rtl/stepdown_softstart_seq.sv
// Soft-start sequencer: precharge, reference ramp, regulation, OCP fault with timed retry.
module stepdown_softstart_seq
  import ss_pkg::*;
#(
  parameter int DAC_W     = 6,
  parameter int STEP_DIV  = 16,
  parameter int PRE_CYC   = 32,
  parameter int OCP_MAX   = 8,
  parameter int RETRY_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             uvlo_n,
  input  logic             ocp,
  output logic             Tstate,
  output logic [DAC_W-1:0] ss_code,
  output logic             ss_done,
  output logic             pg,
  output logic             fault,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB
);

  localparam int DW_W = clog2((PRE_CYC > RETRY_CYC) ? PRE_CYC : RETRY_CYC);
  localparam int PS_W = clog2(STEP_DIV);
  localparam int OC_W = clog2(OCP_MAX + 1);
  localparam logic [DAC_W-1:0] CODE_MAX   = '1;
  localparam logic [DW_W-1:0]  PRE_LAST   = DW_W'(PRE_CYC - 1);
  localparam logic [DW_W-1:0]  RETRY_LAST = DW_W'(RETRY_CYC - 1);
  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(STEP_DIV - 1);
  localparam logic [OC_W-1:0]  OC_LIMIT   = OC_W'(OCP_MAX);

  ss_state_e        state_d, state_q;
  logic [DAC_W-1:0] code_d, code_q;
  logic [OC_W-1:0]  ocp_cnt_d, ocp_cnt_q;
  logic             tstate_d, tstate_q;
  logic             done_d, done_q;
  logic             pg_d, pg_q;
  logic             fault_d, fault_q;
  logic             dw_clr_s, dw_inc_s, dw_tc_s;
  logic [DW_W-1:0]  dw_last_s;
  logic             ps_clr_s, ps_inc_s, ps_tc_s;
  logic             unused_supply_s;

  // Supply pins exist only so the netlist carries them through.
  assign unused_supply_s = CELV ^ CELG ^ SUB;

  // One dwell timer serves both precharge and fault-retry; the limit follows the state.
  assign dw_last_s = (state_q == FAULT) ? RETRY_LAST : PRE_LAST;

  ss_timer #(.W(DW_W)) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (dw_clr_s),
    .inc  (dw_inc_s),
    .last (dw_last_s),
    .tc   (dw_tc_s)
  );

  ss_timer #(.W(PS_W)) u_prescale (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ps_clr_s),
    .inc  (ps_inc_s),
    .last (PS_LAST),
    .tc   (ps_tc_s)
  );

  // Next state; disable/UVLO beats OCP fault, which beats ramp advance.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ocp_cnt_d = '0;
    dw_clr_s  = 1'b0;
    dw_inc_s  = 1'b0;
    ps_clr_s  = 1'b0;
    ps_inc_s  = 1'b0;
    if (!(en && uvlo_n)) begin
      state_d  = OFF;
      code_d   = '0;
      dw_clr_s = 1'b1;
      ps_clr_s = 1'b1;
    end else begin
      case (state_q)
        OFF: begin
          state_d  = PRE;
          code_d   = '0;
          dw_clr_s = 1'b1;
        end
        PRE: begin
          code_d = '0;
          if (dw_tc_s) begin
            state_d  = RAMP;
            dw_clr_s = 1'b1;
            ps_clr_s = 1'b1;
          end else begin
            dw_inc_s = 1'b1;
          end
        end
        RAMP, REG: begin
          ocp_cnt_d = ocp ? (ocp_cnt_q + 1'b1) : '0;
          if (ocp_cnt_d == OC_LIMIT) begin
            state_d   = FAULT;
            code_d    = '0;
            ocp_cnt_d = '0;
            dw_clr_s  = 1'b1;
            ps_clr_s  = 1'b1;
          end else if ((state_q == RAMP) && !ocp) begin
            if (ps_tc_s) begin
              ps_clr_s = 1'b1;
              if (code_q == CODE_MAX) begin
                state_d = REG;
              end else begin
                code_d = code_q + 1'b1;
              end
            end else begin
              ps_inc_s = 1'b1;
            end
          end else begin
            code_d = code_q;
          end
        end
        FAULT: begin
          code_d = '0;
          if (dw_tc_s) begin
            state_d  = PRE;
            dw_clr_s = 1'b1;
          end else begin
            dw_inc_s = 1'b1;
          end
        end
        default: begin
          state_d  = OFF;
          code_d   = '0;
          dw_clr_s = 1'b1;
          ps_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs line up with the state register.
  always_comb begin
    tstate_d = (state_d == RAMP) || (state_d == REG);
    done_d   = (state_d == REG);
    pg_d     = (state_d == REG) && (ocp_cnt_d == '0);
    fault_d  = (state_d == FAULT);
  end

  // State, code, OCP run length and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      code_q    <= '0;
      ocp_cnt_q <= '0;
      tstate_q  <= 1'b0;
      done_q    <= 1'b0;
      pg_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      ocp_cnt_q <= ocp_cnt_d;
      tstate_q  <= tstate_d;
      done_q    <= done_d;
      pg_q      <= pg_d;
      fault_q   <= fault_d;
    end
  end

  assign Tstate  = tstate_q;
  assign ss_code = code_q;
  assign ss_done = done_q;
  assign pg      = pg_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_stepdown_softstart_seq.sv
// Scoreboard bench: stimulus queues each expected output change (cycle, value); a monitor pops on every change.
module tb_stepdown_softstart_seq;

  localparam int DAC_W     = 6;
  localparam int STEP_DIV  = 16;
  localparam int PRE_CYC   = 32;
  localparam int OCP_MAX   = 8;
  localparam int RETRY_CYC = 1024;
  localparam int CODE_MAX  = (1 << DAC_W) - 1;
  localparam int RAMP_LEN  = STEP_DIV * (CODE_MAX + 1);

  logic             clk;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             uvlo_n = 1'b0;
  logic             ocp = 1'b0;
  logic             celv = 1'b1;
  logic             celg = 1'b0;
  logic             sub = 1'b0;
  logic             tstate, ss_done, pg, fault;
  logic [DAC_W-1:0] ss_code;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int                 q_at[$];
  logic [DAC_W+3:0]   q_val[$];
  string              q_tag[$];

  stepdown_softstart_seq #(
    .DAC_W(DAC_W), .STEP_DIV(STEP_DIV), .PRE_CYC(PRE_CYC),
    .OCP_MAX(OCP_MAX), .RETRY_CYC(RETRY_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .uvlo_n(uvlo_n), .ocp(ocp),
    .Tstate(tstate), .ss_code(ss_code), .ss_done(ss_done), .pg(pg), .fault(fault),
    .CELV(celv), .CELG(celg), .SUB(sub)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DAC_W+3:0] mk(input bit t, input int code, input bit d, input bit p, input bit f);
    return {t, code[DAC_W-1:0], d, p, f};
  endfunction

  task automatic expect_at(input int at, input logic [DAC_W+3:0] v, input string tag);
    q_at.push_back(at);
    q_val.push_back(v);
    q_tag.push_back(tag);
  endtask

  task automatic push_codes(input int r, input int c0, input int c1, input int off);
    for (int c = c0; c <= c1; c++) expect_at(r + STEP_DIV * c + off, mk(1, c, 0, 0, 0), "ramp_code");
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change of the output vector is one presented result.
  logic [DAC_W+3:0] mon_last;
  logic [DAC_W+3:0] mon_cur;
  bit               mon_first = 1'b1;
  initial begin
    int               at;
    logic [DAC_W+3:0] v;
    string            tag;
    forever begin
      @(negedge clk);
      mon_cur = {tstate, ss_code, ss_done, pg, fault};
      if (mon_first || (mon_cur !== mon_last)) begin
        mon_first = 1'b0;
        mon_last  = mon_cur;
        total++;
        if (q_at.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got val=%b at cyc=%0d, required no change", mon_cur, cyc);
        end else begin
          at  = q_at.pop_front();
          v   = q_val.pop_front();
          tag = q_tag.pop_front();
          if ((mon_cur !== v) || ((at >= 0) && (at != cyc))) begin
            bad++;
            $display("FAIL %s: got val=%b cyc=%0d, required val=%b cyc=%0d", tag, mon_cur, cyc, v, at);
          end
        end
      end
    end
  end

  initial begin
    int r;
    int m;
    int s;
    int u;
    expect_at(-1, mk(0, 0, 0, 0, 0), "reset_state");
    step(3);
    rst_n = 1'b1;
    step(2);

    // Nominal start: PRE lasts PRE_CYC cycles, then a full ramp into REG.
    en = 1'b1;
    uvlo_n = 1'b1;
    r = cyc + 1 + PRE_CYC;
    expect_at(r, mk(1, 0, 0, 0, 0), "tstate_on");
    push_codes(r, 1, CODE_MAX, 0);
    expect_at(r + RAMP_LEN, mk(1, CODE_MAX, 1, 1, 0), "reg_pg");
    step(r + RAMP_LEN + 5 - cyc);

    // OCP_MAX consecutive ocp cycles in REG: pg drops at once, then FAULT.
    m = cyc;
    ocp = 1'b1;
    expect_at(m + 1, mk(1, CODE_MAX, 1, 0, 0), "pg_drop");
    expect_at(m + OCP_MAX, mk(0, 0, 0, 0, 1), "fault_entry");
    expect_at(m + OCP_MAX + RETRY_CYC, mk(0, 0, 0, 0, 0), "retry_to_pre");
    step(OCP_MAX);
    ocp = 1'b0;

    // Retry ramp with a 3-cycle ocp glitch after code 5: later codes slip 3 cycles.
    r = m + OCP_MAX + RETRY_CYC + PRE_CYC;
    expect_at(r, mk(1, 0, 0, 0, 0), "retry_tstate_on");
    push_codes(r, 1, 5, 0);
    push_codes(r, 6, 10, 3);
    step(r + STEP_DIV * 5 + 4 - cyc);
    s = cyc;
    ocp = 1'b1;
    step(3);
    ocp = 1'b0;

    // UVLO drop mid-ramp: OFF next cycle, then a complete PRE + RAMP rerun.
    step(r + STEP_DIV * 10 + 3 + 2 - cyc);
    u = cyc;
    uvlo_n = 1'b0;
    expect_at(u + 1, mk(0, 0, 0, 0, 0), "uvlo_off");
    step(3);
    uvlo_n = 1'b1;
    r = u + 4 + PRE_CYC;
    expect_at(r, mk(1, 0, 0, 0, 0), "rerun_tstate_on");
    push_codes(r, 1, 20, 0);

    // Async reset at code 20: outputs clear without a clock edge.
    step(r + STEP_DIV * 20 + 3 - cyc);
    expect_at(cyc, mk(0, 0, 0, 0, 0), "async_reset");
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    r = cyc + 1 + PRE_CYC;
    expect_at(r, mk(1, 0, 0, 0, 0), "post_reset_tstate_on");
    push_codes(r, 1, CODE_MAX, 0);
    expect_at(r + RAMP_LEN, mk(1, CODE_MAX, 1, 1, 0), "post_reset_reg");
    step(r + RAMP_LEN + 4 - cyc);

    // en falls on the same cycle as the last ocp: OFF wins, fault stays low.
    m = cyc;
    ocp = 1'b1;
    expect_at(m + 1, mk(1, CODE_MAX, 1, 0, 0), "pg_drop2");
    expect_at(m + OCP_MAX, mk(0, 0, 0, 0, 0), "disable_beats_fault");
    step(OCP_MAX - 1);
    en = 1'b0;
    step(1);
    ocp = 1'b0;
    step(20);

    while (q_at.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no change, required val=%b at cyc=%0d", q_tag[0], q_val[0], q_at[0]);
      void'(q_at.pop_front());
      void'(q_val.pop_front());
      void'(q_tag.pop_front());
    end
    if (s < 0) $display("glitch start cyc=%0d", s);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
